alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
Multi-cycle, parametrised integer ALU with RV32M/RV64M multiply/divide support. Sits in the execute stage and uses a valid/ready handshake on both the input and result sides.
- Base RV-I ops complete in 1 cycle.
- M-extension ops run through an iterative shift-add / restoring-divide core.
- Fixes SLTU: it is a true unsigned compare.
- Adds signed/unsigned high-half multiply, divide and remainder.

Parameters:
XLEN, 32, datapath width (32 or 64)
M_EN, 1, 1 = M-extension ops enabled; 0 = mext input ignored and ops decode as base
SHAMT_W, $clog2(XLEN), localparam; shift amount = b[SHAMT_W-1:0]

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand/op presented
in_ready  out  1  block accepts a new op
a  in  XLEN  operand rs1
b  in  XLEN  operand rs2 or immediate
op  in  3  funct3
sel  in  1  funct7[5]: SUB vs ADD, SRA vs SRL
mext  in  1  funct7[0]: M-extension op
kill  in  1  abort in-flight op (pipeline flush)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  XLEN  registered result
zero  out  1  result == 0, derived from the registered result
busy  out  1  iterative op in progress

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, out_valid=0, result=0, zero=1, busy=0, in_ready=1. Reset mid-operation drops the op with no output.
- States:
  - IDLE: in_ready=1.
  - CALC: busy=1, iterative op.
  - DONE: out_valid=1, result held stable until out_ready.
- Accept: a new op is captured only when in_valid && in_ready. in_ready = (state==IDLE).
- Base ops (mext=0 or M_EN=0), IDLE -> DONE; out_valid is asserted the cycle after accept (latency 1):
  - 000: ADD, or SUB when sel=1.
  - 001: SLL.
  - 010: SLT, signed.
  - 011: SLTU, unsigned. Result is {0..0, flag}.
  - 100: XOR.
  - 101: SRL, or SRA when sel=1.
  - 110: OR.
  - 111: AND.
- M ops (mext=1, M_EN=1), IDLE -> CALC for exactly XLEN cycles, then DONE. out_valid is asserted XLEN+1 cycles after accept.
  - 000: MUL, low half.
  - 001: MULH, signed×signed, high half.
  - 010: MULHSU, signed×unsigned, high half.
  - 011: MULHU, unsigned×unsigned, high half.
  - 100: DIV.
  - 101: DIVU.
  - 110: REM.
  - 111: REMU.
- Signed M ops operate on magnitudes; the result sign is fixed up in the last CALC cycle.
- Divide by zero (b==0):
  - DIV/DIVU: quotient = all ones.
  - REM/REMU: remainder = a.
  - Still takes full latency.
- Signed overflow (a = most-negative, b = -1): DIV gives the most-negative value; REM gives 0.
- DONE -> IDLE when out_ready is high. There is no back-to-back accept in the same cycle; the next op is accepted in the following IDLE cycle.
- kill: any state -> IDLE next cycle, out_valid=0, busy=0. kill has priority over out_ready and in_valid. kill in IDLE blocks an accept in that cycle.
- Operands are latched at accept. Later changes on a/b/op do not affect an in-flight op.
- zero tracks result in every state.

Decomposition:
- Package alu_pkg:
  - funct3 localparams: F3_ADD … F3_AND, F3_MUL … F3_REMU.
  - State enum: IDLE, CALC, DONE.
  - Div-by-zero/overflow result constants as functions of XLEN.
- Sub-module mdu_iter, the iterative multiply/divide core:
  - Inputs: start, operands, op, signedness flags.
  - Outputs: done pulse, result.
  - Contains the counter, shift registers and sign fix-up.
  - alu_mc owns the handshake FSM, the base-op datapath and the result register.

Test Plan:
1. Base ops, XLEN=32. Each must give out_valid exactly 1 cycle after accept:
   - SUB, a=5, b=7 -> 0xFFFFFFFE, zero=0.
   - SLTU, a=0xFFFFFFFF, b=1 -> 0.
   - SLT, same operands -> 1.
   - SRA, a=0x80000000, b=0x21 -> 0xC0000000 (shamt=1).
2. MULH, a=0x80000000, b=0x80000000 -> 0x40000000. MULHU, same operands -> 0x40000000. out_valid exactly 33 cycles after accept; busy=1 for 32 cycles.
3. Divide edge cases:
   - DIV 7/0 -> 0xFFFFFFFF.
   - REM 7/0 -> 7.
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
   - REM, same operands -> 0.
   - DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF.
4. Back-pressure: hold out_ready=0 for 5 cycles after out_valid. result and out_valid must stay stable and in_ready=0. Raise out_ready -> IDLE next cycle.
5. kill at CALC cycle 10 of a DIVU -> next cycle out_valid=0, busy=0, in_ready=1, and no stale result appears. rst_n pulse mid-MUL -> outputs reach reset values asynchronously.
6. XLEN=64, M_EN=0: mext=1 with op=000 performs ADD. MULHU 0xFFFF…F × 2 (XLEN=64, M_EN=1) -> 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: funct3 codes, FSM states and
// the fixed results used for divide-by-zero and signed-overflow division.
package alu_pkg;

    // Base integer funct3 codes
    localparam logic [2:0] F3_ADD    = 3'b000;
    localparam logic [2:0] F3_SLL    = 3'b001;
    localparam logic [2:0] F3_SLT    = 3'b010;
    localparam logic [2:0] F3_SLTU   = 3'b011;
    localparam logic [2:0] F3_XOR    = 3'b100;
    localparam logic [2:0] F3_SR     = 3'b101;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;

    // Multiply/divide funct3 codes
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Quotient for a zero divisor: all ones in the low xlen bits
    function automatic logic [63:0] div_zero_quot(input int xlen);
        return {64{1'b1}} >> (64 - xlen);
    endfunction

    // Most-negative xlen-bit value: quotient of min / -1
    function automatic logic [63:0] div_ovf_quot(input int xlen);
        return 64'd1 << (xlen - 1);
    endfunction

endpackage

// File: rtl/alu_mc_mdu.sv
// Iterative multiply/divide core. Works on operand magnitudes: shift-add
// multiply or restoring divide, one bit per cycle for XLEN cycles. During the
// last cycle it exposes the sign-corrected result together with a done pulse.
module mdu_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            kill,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      op,
    input  logic            a_signed,
    input  logic            b_signed,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [63:0]       DIVZ_Q64 = div_zero_quot(XLEN);
    localparam logic [63:0]       OVF_Q64  = div_ovf_quot(XLEN);
    localparam logic [XLEN-1:0]   DIVZ_Q   = DIVZ_Q64[XLEN-1:0];
    localparam logic [XLEN-1:0]   OVF_Q    = OVF_Q64[XLEN-1:0];
    localparam logic [XLEN-1:0]   ONE      = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0] ONE2     = {{(2*XLEN-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(XLEN - 1);

    logic               run_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [XLEN-1:0]    hi_r;      // product high half / partial remainder
    logic [XLEN-1:0]    lo_r;      // multiplier / dividend shifting into quotient
    logic [XLEN-1:0]    mcand_r;   // multiplicand or divisor magnitude
    logic               is_div_r;
    logic               hi_sel_r;
    logic               rem_sel_r;
    logic               neg_r;
    logic               bzero_r;
    logic               ovf_r;
    logic [XLEN-1:0]    a_r;

    logic               a_neg_s;
    logic               b_neg_s;
    logic [XLEN-1:0]    a_mag_s;
    logic [XLEN-1:0]    b_mag_s;
    logic [XLEN-1:0]    mul_add_s;
    logic [XLEN:0]      mul_sum_s;
    logic [XLEN:0]      div_shift_s;
    logic [XLEN:0]      div_trial_s;
    logic [XLEN-1:0]    hi_nxt_s;
    logic [XLEN-1:0]    lo_nxt_s;
    logic [2*XLEN-1:0]  prod_s;
    logic [2*XLEN-1:0]  prod_fix_s;
    logic [XLEN-1:0]    quo_fix_s;
    logic [XLEN-1:0]    rem_fix_s;

    // Operand magnitudes taken at start
    always_comb begin
        a_neg_s = a_signed & a[XLEN-1];
        b_neg_s = b_signed & b[XLEN-1];
        if (a_neg_s) begin
            a_mag_s = ~a + ONE;
        end else begin
            a_mag_s = a;
        end
        if (b_neg_s) begin
            b_mag_s = ~b + ONE;
        end else begin
            b_mag_s = b;
        end
    end

    // One iteration step of either shift-add multiply or restoring divide
    always_comb begin
        mul_add_s   = lo_r[0] ? mcand_r : {XLEN{1'b0}};
        mul_sum_s   = {1'b0, hi_r} + {1'b0, mul_add_s};
        div_shift_s = {hi_r, lo_r[XLEN-1]};
        div_trial_s = div_shift_s - {1'b0, mcand_r};
        if (is_div_r) begin
            if (!div_trial_s[XLEN]) begin
                hi_nxt_s = div_trial_s[XLEN-1:0];
                lo_nxt_s = {lo_r[XLEN-2:0], 1'b1};
            end else begin
                hi_nxt_s = div_shift_s[XLEN-1:0];
                lo_nxt_s = {lo_r[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_nxt_s = mul_sum_s[XLEN:1];
            lo_nxt_s = {mul_sum_s[0], lo_r[XLEN-1:1]};
        end
    end

    // Sign fix-up and special-case selection on the final step's value
    always_comb begin
        prod_s     = {hi_nxt_s, lo_nxt_s};
        prod_fix_s = neg_r ? (~prod_s + ONE2) : prod_s;
        quo_fix_s  = neg_r ? (~lo_nxt_s + ONE) : lo_nxt_s;
        rem_fix_s  = neg_r ? (~hi_nxt_s + ONE) : hi_nxt_s;
        if (is_div_r) begin
            if (rem_sel_r) begin
                if (bzero_r) begin
                    result = a_r;
                end else if (ovf_r) begin
                    result = {XLEN{1'b0}};
                end else begin
                    result = rem_fix_s;
                end
            end else begin
                if (bzero_r) begin
                    result = DIVZ_Q;
                end else if (ovf_r) begin
                    result = OVF_Q;
                end else begin
                    result = quo_fix_s;
                end
            end
        end else begin
            result = hi_sel_r ? prod_fix_s[2*XLEN-1:XLEN] : prod_fix_s[XLEN-1:0];
        end
        done = run_r && (cnt_r == CNT_LAST);
    end

    // Load operands on start, then iterate until the counter wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_r     <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            hi_r      <= {XLEN{1'b0}};
            lo_r      <= {XLEN{1'b0}};
            mcand_r   <= {XLEN{1'b0}};
            is_div_r  <= 1'b0;
            hi_sel_r  <= 1'b0;
            rem_sel_r <= 1'b0;
            neg_r     <= 1'b0;
            bzero_r   <= 1'b0;
            ovf_r     <= 1'b0;
            a_r       <= {XLEN{1'b0}};
        end else if (kill) begin
            run_r <= 1'b0;
            cnt_r <= {CNT_W{1'b0}};
        end else if (start) begin
            run_r     <= 1'b1;
            cnt_r     <= {CNT_W{1'b0}};
            hi_r      <= {XLEN{1'b0}};
            is_div_r  <= op[2];
            hi_sel_r  <= (op != F3_MUL);
            rem_sel_r <= op[1];
            neg_r     <= (op[2] && op[1]) ? a_neg_s : (a_neg_s ^ b_neg_s);
            bzero_r   <= (b == {XLEN{1'b0}});
            ovf_r     <= op[2] & a_signed & b_signed & (a == OVF_Q) & (b == DIVZ_Q);
            a_r       <= a;
            if (op[2]) begin
                lo_r    <= a_mag_s;
                mcand_r <= b_mag_s;
            end else begin
                lo_r    <= b_mag_s;
                mcand_r <= a_mag_s;
            end
        end else if (run_r) begin
            hi_r  <= hi_nxt_s;
            lo_r  <= lo_nxt_s;
            cnt_r <= cnt_r + CNT_ONE;
            if (cnt_r == CNT_LAST) begin
                run_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU: single-cycle base ops, iterative M-extension
// ops through mdu_iter, valid/ready handshake on both sides and a flush input.
module alu_mc
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter bit M_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      op,
    input  logic            sel,
    input  logic            mext,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    localparam int SHAMT_W = $clog2(XLEN);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [XLEN-1:0]    result_r;
    logic [XLEN-1:0]    result_nxt_s;
    logic               out_valid_r;
    logic               busy_r;
    logic               in_ready_r;
    logic               zero_r;

    logic               is_m_s;
    logic [SHAMT_W-1:0] shamt_s;
    logic [XLEN-1:0]    base_s;
    logic               a_signed_s;
    logic               b_signed_s;
    logic               mdu_start_s;
    logic               mdu_done_s;
    logic [XLEN-1:0]    mdu_res_s;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign result    = result_r;
    assign zero      = zero_r;

    assign is_m_s  = M_EN & mext;
    assign shamt_s = b[SHAMT_W-1:0];

    // Single-cycle base integer datapath
    always_comb begin
        case (op)
            F3_ADD:  base_s = sel ? (a - b) : (a + b);
            F3_SLL:  base_s = a << shamt_s;
            F3_SLT:  base_s = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            F3_SLTU: base_s = {{(XLEN-1){1'b0}}, (a < b)};
            F3_XOR:  base_s = a ^ b;
            F3_SR:   base_s = sel ? $unsigned($signed(a) >>> shamt_s) : (a >> shamt_s);
            F3_OR:   base_s = a | b;
            F3_AND:  base_s = a & b;
            default: base_s = {XLEN{1'b0}};
        endcase
    end

    // Operand signedness for the multiply/divide core
    always_comb begin
        case (op)
            F3_MULH:   begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            F3_MULHSU: begin a_signed_s = 1'b1; b_signed_s = 1'b0; end
            F3_DIV:    begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            F3_REM:    begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            default:   begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
        endcase
    end

    // Handshake FSM next state and result selection; kill wins over everything
    always_comb begin
        state_nxt_s  = state_r;
        result_nxt_s = result_r;
        mdu_start_s  = 1'b0;
        if (kill) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        if (is_m_s) begin
                            state_nxt_s = CALC;
                            mdu_start_s = 1'b1;
                        end else begin
                            state_nxt_s  = DONE;
                            result_nxt_s = base_s;
                        end
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                CALC: begin
                    if (mdu_done_s) begin
                        state_nxt_s  = DONE;
                        result_nxt_s = mdu_res_s;
                    end else begin
                        state_nxt_s = CALC;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = DONE;
                    end
                end
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // State, result and handshake flags, all registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            result_r    <= {XLEN{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            zero_r      <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            result_r    <= result_nxt_s;
            out_valid_r <= (state_nxt_s == DONE);
            busy_r      <= (state_nxt_s == CALC);
            in_ready_r  <= (state_nxt_s == IDLE);
            zero_r      <= (result_nxt_s == {XLEN{1'b0}});
        end
    end

    mdu_iter #(
        .XLEN(XLEN)
    ) u_mdu (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (mdu_start_s),
        .kill     (kill),
        .a        (a),
        .b        (b),
        .op       (op),
        .a_signed (a_signed_s),
        .b_signed (b_signed_s),
        .done     (mdu_done_s),
        .result   (mdu_res_s)
    );

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: three instances (32-bit with M ops, 64-bit
// without, 64-bit with), directed edge cases plus randomized ops checked
// against an arithmetic reference model.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] a_s, b_s;
    logic [2:0]  op_s;
    logic        sel_s, mext_s;
    logic [2:0]  iv, ordy, kl;
    logic [2:0]  ov, ir, bz, zr;
    logic [31:0] res32;
    logic [63:0] res64n, res64m;
    int          n_checks = 0;
    int          n_errs   = 0;

    always #5 clk = ~clk;

    alu_mc #(.XLEN(32), .M_EN(1'b1)) u_d32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a_s[31:0]), .b(b_s[31:0]), .op(op_s), .sel(sel_s), .mext(mext_s),
        .kill(kl[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .result(res32),
        .zero(zr[0]), .busy(bz[0]));

    alu_mc #(.XLEN(64), .M_EN(1'b0)) u_d64n (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a_s), .b(b_s), .op(op_s), .sel(sel_s), .mext(mext_s),
        .kill(kl[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .result(res64n),
        .zero(zr[1]), .busy(bz[1]));

    alu_mc #(.XLEN(64), .M_EN(1'b1)) u_d64m (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a_s), .b(b_s), .op(op_s), .sel(sel_s), .mext(mext_s),
        .kill(kl[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .result(res64m),
        .zero(zr[2]), .busy(bz[2]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int xlw(input int w);
        return (w == 0) ? 32 : 64;
    endfunction

    function automatic logic [63:0] get_res(input int w);
        if (w == 0) return {32'd0, res32};
        else if (w == 1) return res64n;
        else return res64m;
    endfunction

    // Reference: plain 128-bit arithmetic on sign/zero-extended operands
    function automatic logic [63:0] ref_alu(input int xl, input bit men, input logic [2:0] op,
                                            input bit sel, input bit mext,
                                            input logic [63:0] a_in, input logic [63:0] b_in);
        logic [63:0]         mask, a, b, r;
        logic signed [127:0] sa, sb, ua, ub, p;
        int                  sh;
        mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        a  = a_in & mask;
        b  = b_in & mask;
        sa = (xl == 64) ? {{64{a[63]}}, a} : {{96{a[31]}}, a[31:0]};
        sb = (xl == 64) ? {{64{b[63]}}, b} : {{96{b[31]}}, b[31:0]};
        ua = {64'd0, a};
        ub = {64'd0, b};
        sh = int'(b[5:0]) % xl;
        r  = 64'd0;
        if (men && mext) begin
            case (op)
                3'd0: r = a * b;
                3'd1: begin p = sa * sb; r = 64'(p >>> xl); end
                3'd2: begin p = sa * ub; r = 64'(p >>> xl); end
                3'd3: begin p = ua * ub; r = 64'(p >>> xl); end
                3'd4: r = (b == 64'd0) ? mask : 64'(sa / sb);
                3'd5: r = (b == 64'd0) ? mask : 64'(ua / ub);
                3'd6: r = (b == 64'd0) ? a : 64'(sa % sb);
                default: r = (b == 64'd0) ? a : 64'(ua % ub);
            endcase
        end else begin
            case (op)
                3'd0: r = sel ? (a - b) : (a + b);
                3'd1: r = a << sh;
                3'd2: r = (sa < sb) ? 64'd1 : 64'd0;
                3'd3: r = (a < b) ? 64'd1 : 64'd0;
                3'd4: r = a ^ b;
                3'd5: begin
                    if (sel) r = 64'(sa >>> sh);
                    else r = a >> sh;
                end
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end
        return r & mask;
    endfunction

    function automatic logic [63:0] rnd_val(input int xl);
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0: v = 64'd0;
            1: v = 64'hFFFF_FFFF_FFFF_FFFF;
            2: v = 64'd1 << (xl - 1);
            3: v = 64'($urandom_range(0, 15));
            default: v = {$urandom, $urandom};
        endcase
        return (xl == 64) ? v : {32'd0, v[31:0]};
    endfunction

    task automatic do_op(input int w, input logic [2:0] op, input bit sel, input bit mext,
                         input logic [63:0] a, input logic [63:0] b, input string tag,
                         input int hold);
        logic [63:0] exp, held;
        int          lat, busy_n, exp_lat;
        bit          is_m;
        is_m    = (w != 1) && mext;
        exp     = ref_alu(xlw(w), w != 1, op, sel, mext, a, b);
        exp_lat = is_m ? xlw(w) + 1 : 1;
        chk({tag, "/in_ready"}, 64'(ir[w]), 64'd1);
        a_s = a; b_s = b; op_s = op; sel_s = sel; mext_s = mext; iv[w] = 1'b1;
        @(posedge clk); #1;
        iv[w] = 1'b0;
        a_s = {$urandom, $urandom}; b_s = {$urandom, $urandom};
        op_s = 3'($urandom); sel_s = 1'($urandom); mext_s = 1'($urandom);
        lat = 1; busy_n = 0;
        while (!ov[w] && lat < 200) begin
            if (bz[w]) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "/latency"}, 64'(lat), 64'(exp_lat));
        if (is_m) chk({tag, "/busy_cycles"}, 64'(busy_n), 64'(xlw(w)));
        chk({tag, "/busy_done"}, 64'(bz[w]), 64'd0);
        chk({tag, "/result"}, get_res(w), exp);
        chk({tag, "/zero"}, 64'(zr[w]), (exp == 64'd0) ? 64'd1 : 64'd0);
        held = get_res(w);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "/hold_valid"}, 64'(ov[w]), 64'd1);
            chk({tag, "/hold_ready"}, 64'(ir[w]), 64'd0);
            chk({tag, "/hold_result"}, get_res(w), held);
        end
        ordy[w] = 1'b1;
        @(posedge clk); #1;
        ordy[w] = 1'b0;
        chk({tag, "/release_valid"}, 64'(ov[w]), 64'd0);
        chk({tag, "/release_ready"}, 64'(ir[w]), 64'd1);
    endtask

    task automatic chk_reset(input int w, input string tag);
        chk({tag, "/in_ready"}, 64'(ir[w]), 64'd1);
        chk({tag, "/out_valid"}, 64'(ov[w]), 64'd0);
        chk({tag, "/busy"}, 64'(bz[w]), 64'd0);
        chk({tag, "/zero"}, 64'(zr[w]), 64'd1);
        chk({tag, "/result"}, get_res(w), 64'd0);
    endtask

    initial begin
        int stale;
        rst_n = 1'b0; iv = 3'b000; ordy = 3'b000; kl = 3'b000;
        a_s = 64'd0; b_s = 64'd0; op_s = 3'd0; sel_s = 1'b0; mext_s = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int w = 0; w < 3; w++) chk_reset(w, "reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Base ops
        do_op(0, 3'b000, 1'b1, 1'b0, 64'd5, 64'd7, "sub", 0);
        do_op(0, 3'b011, 1'b0, 1'b0, 64'hFFFF_FFFF, 64'd1, "sltu", 0);
        do_op(0, 3'b010, 1'b0, 1'b0, 64'hFFFF_FFFF, 64'd1, "slt", 0);
        do_op(0, 3'b101, 1'b1, 1'b0, 64'h8000_0000, 64'h21, "sra", 0);

        // High-half multiplies
        do_op(0, 3'b001, 1'b0, 1'b1, 64'h8000_0000, 64'h8000_0000, "mulh", 0);
        do_op(0, 3'b011, 1'b0, 1'b1, 64'h8000_0000, 64'h8000_0000, "mulhu", 0);

        // Divide edge cases
        do_op(0, 3'b100, 1'b0, 1'b1, 64'd7, 64'd0, "div_by0", 0);
        do_op(0, 3'b110, 1'b0, 1'b1, 64'd7, 64'd0, "rem_by0", 0);
        do_op(0, 3'b100, 1'b0, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, "div_ovf", 0);
        do_op(0, 3'b110, 1'b0, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, "rem_ovf", 0);
        do_op(0, 3'b100, 1'b0, 1'b1, 64'hFFFF_FFF9, 64'd2, "div_neg", 0);
        do_op(0, 3'b110, 1'b0, 1'b1, 64'hFFFF_FFF9, 64'd2, "rem_neg", 0);

        // Back-pressure
        do_op(0, 3'b111, 1'b0, 1'b0, 64'h1234_5678, 64'h0FF0_0FF0, "bp_base", 5);
        do_op(0, 3'b000, 1'b0, 1'b1, 64'h0001_2345, 64'h0000_0100, "bp_mul", 5);

        // kill during CALC cycle 10 of a DIVU
        a_s = 64'd1000; b_s = 64'd7; op_s = 3'b101; sel_s = 1'b0; mext_s = 1'b1; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        chk("kill/busy_before", 64'(bz[0]), 64'd1);
        kl[0] = 1'b1;
        @(posedge clk); #1;
        kl[0] = 1'b0;
        chk("kill/out_valid", 64'(ov[0]), 64'd0);
        chk("kill/busy", 64'(bz[0]), 64'd0);
        chk("kill/in_ready", 64'(ir[0]), 64'd1);
        stale = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ov[0] || bz[0]) stale++;
        end
        chk("kill/no_stale", 64'(stale), 64'd0);

        // kill in IDLE blocks the accept
        a_s = 64'd3; b_s = 64'd4; op_s = 3'b000; mext_s = 1'b0; iv[0] = 1'b1; kl[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0; kl[0] = 1'b0;
        chk("kill_idle/in_ready", 64'(ir[0]), 64'd1);
        chk("kill_idle/out_valid", 64'(ov[0]), 64'd0);
        @(posedge clk); #1;
        chk("kill_idle/out_valid2", 64'(ov[0]), 64'd0);

        // Asynchronous reset in the middle of a MUL
        do_op(0, 3'b000, 1'b0, 1'b0, 64'd9, 64'd9, "pre_rst", 0);
        a_s = 64'd12345; b_s = 64'd678; op_s = 3'b000; mext_s = 1'b1; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        chk("rst_mid/busy_before", 64'(bz[0]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset(0, "rst_mid");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid/out_valid_after", 64'(ov[0]), 64'd0);
        chk("rst_mid/in_ready_after", 64'(ir[0]), 64'd1);

        // 64-bit variants
        do_op(1, 3'b000, 1'b0, 1'b1, 64'h0000_0001_0000_0001, 64'h7, "m_en0_add", 0);
        do_op(2, 3'b011, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, "mulhu64", 0);

        // Randomized ops
        for (int i = 0; i < 40; i++)
            do_op(0, 3'($urandom), 1'($urandom), 1'($urandom), rnd_val(32), rnd_val(32),
                  "rnd32", $urandom_range(0, 2));
        for (int i = 0; i < 12; i++)
            do_op(2, 3'($urandom), 1'($urandom), 1'($urandom), rnd_val(64), rnd_val(64),
                  "rnd64m", $urandom_range(0, 1));
        for (int i = 0; i < 10; i++)
            do_op(1, 3'($urandom), 1'($urandom), 1'($urandom), rnd_val(64), rnd_val(64),
                  "rnd64n", 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
